booth_seq_ctrl: RTL and testbench

Iterative radix-4 Booth multiplier sequencer: accepts one signed operand pair per start handshake and evaluates one Booth partial product per clock in a shared N+1-bit partial-product generator and a single 2N-bit accumulator. It trades the all-combinational, K-adder structure for K cycles of latency and serves area-constrained datapaths in the karatsuba tree. Results are bit-identical to the combinational radix-4 multiplier: signed(x)·signed(y) mod 2^(2N).

---
 rtl/booth_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_booth_seq_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier: one partial product per clock into a 2N-bit accumulator.
// Optional build macro BOOTH_SEQ_ZERO_SKIP_EN ends the run early once remaining groups encode zero.
module booth_seq_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int K  = N / 2;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] p_q, p_d;
    logic [N-1:0]   x_q, x_d, y_q, y_d;
    logic           done_q, done_d;

    logic [N:0]     y_ext;
    logic [2:0]     triple;
    logic           pp_zero, pp_neg, pp_two;
    logic [N:0]     pp_mag;
    logic [2*N-1:0] pp_full, pp_sh, sum;
    logic           finish;
    logic [N-1:0]   y_rest;

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign p     = p_q;

    always_comb begin
        y_ext   = {y_q, 1'b0};
        triple  = y_ext[{count_q, 1'b0} +: 3];
        pp_zero = 1'b0;
        pp_neg  = 1'b0;
        pp_two  = 1'b0;
        case (triple)
            3'b000, 3'b111: pp_zero = 1'b1;
            3'b011:         pp_two  = 1'b1;
            3'b100:         begin pp_two = 1'b1; pp_neg = 1'b1; end
            3'b101, 3'b110: pp_neg  = 1'b1;
            default:        pp_zero = 1'b0;
        endcase
        pp_mag  = pp_two ? {x_q, 1'b0} : {x_q[N-1], x_q};
        // Negate at full width so -2x of the most negative x still fits.
        pp_full = {{(N-1){pp_mag[N]}}, pp_mag};
        if (pp_neg)  pp_full = -pp_full;
        if (pp_zero) pp_full = '0;
        pp_sh   = pp_full << {count_q, 1'b0};
        sum     = acc_q + pp_sh;

        y_rest  = $signed(y_q) >>> ({count_q, 1'b0} + 1'b1);
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
        finish  = (count_q == CW'(K - 1)) || (y_rest == '0) || (y_rest == '1);
`else
        finish  = (count_q == CW'(K - 1));
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        p_d     = p_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (finish) begin
                    p_d     = sum;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d   = sum;
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed-vector bench for booth_seq_ctrl (N=8): products, latency, back-to-back, reset abort.
module tb_booth_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  x, y;
    logic        ready, busy, done;
    logic [15:0] p;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    booth_seq_ctrl #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .ready(ready), .busy(busy), .done(done), .p(p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
        int          lat_skip;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge, return product and edges from accept to done.
    task automatic do_mult(input logic [7:0] xa, input logic [7:0] ya,
                           output logic [15:0] pr, output int lat);
        @(negedge clk);
        start = 1'b1; x = xa; y = ya;
        @(negedge clk);
        start = 1'b0; x = 8'hxx; y = 8'hxx;
        lat = 1;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        pr = p;
    endtask

    initial begin
        logic [15:0] pr;
        int lat, exp_lat, t_prev, t_now, seen;
        logic [7:0] bx[3], by[3];
        logic [15:0] bp[3];

        vecs[0]  = '{8'h07, 8'h05, 16'h0023, 3};
        vecs[1]  = '{8'h80, 8'h80, 16'h4000, 5};
        vecs[2]  = '{8'h7F, 8'h80, 16'hC080, 5};
        vecs[3]  = '{8'hFF, 8'h03, 16'hFFFD, 3};
        vecs[4]  = '{8'h11, 8'h01, 16'h0011, 2};
        vecs[5]  = '{8'h11, 8'hFF, 16'hFFEF, 2};
        vecs[6]  = '{8'h00, 8'h00, 16'h0000, 2};
        vecs[7]  = '{8'h7F, 8'h7F, 16'h3F01, 5};
        vecs[8]  = '{8'h80, 8'h7F, 16'hC080, 5};
        vecs[9]  = '{8'h12, 8'hF0, 16'hFEE0, 4};
        vecs[10] = '{8'hC3, 8'h25, 16'hF72F, 5};
        vecs[11] = '{8'h80, 8'h01, 16'hFF80, 2};

        rst = 1'b1; start = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_p", p, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
            exp_lat = vecs[i].lat_skip;
`else
            exp_lat = 5;
`endif
            do_mult(vecs[i].x, vecs[i].y, pr, lat);
            chk($sformatf("vec%0d_p", i), pr, vecs[i].p);
            chk($sformatf("vec%0d_lat", i), lat, exp_lat);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
            chk($sformatf("vec%0d_p_hold", i), p, vecs[i].p);
        end

        // start held high across three full-latency pairs
        bx = '{8'h80, 8'h7F, 8'hC3}; by = '{8'h80, 8'h7F, 8'h25};
        bp = '{16'h4000, 16'h3F01, 16'hF72F};
        @(negedge clk);
        start = 1'b1; x = bx[0]; y = by[0];
        @(negedge clk);
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin x = bx[k+1]; y = by[k+1]; end
            else start = 1'b0;
            seen = 0;
            while (!done && seen < 50) begin
                chk("b2b_busy_run", busy, 1);
                @(negedge clk);
                seen++;
            end
            t_now = cyc;
            chk($sformatf("b2b%0d_p", k), p, bp[k]);
            chk($sformatf("b2b%0d_busy_in_done", k), busy, 0);
            if (k > 0) chk($sformatf("b2b%0d_gap", k), t_now - t_prev, 5);
            t_prev = t_now;
            @(negedge clk);
        end
        chk("b2b_end_done", done, 0);

        // Reset in the second RUN cycle with start held: abort, p cleared
        do_mult(8'h07, 8'h05, pr, lat);
        @(negedge clk);
        start = 1'b1; x = 8'h07; y = 8'h05;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_p", p, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        rst = 1'b0; start = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);

        // start pulsed during RUN with other operands is ignored
        @(negedge clk);
        start = 1'b1; x = 8'h7F; y = 8'h7F;
        @(negedge clk);
        x = 8'h11; y = 8'h01;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        while (!done && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        chk("ignore_p", p, 16'h3F01);
        @(negedge clk);
        chk("ignore_idle", ready & ~busy, 1);

        // random sweep against a signed golden product
        for (int r = 0; r < 300; r++) begin
            logic [7:0] rx, ry;
            logic [15:0] gp;
            rx = 8'($urandom);
            ry = 8'($urandom);
            gp = 16'($signed(rx) * $signed(ry));
            do_mult(rx, ry, pr, lat);
            chk($sformatf("rand_%0h_%0h", rx, ry), pr, gp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
